instr_mem: RTL and testbench



---
 rtl/instr_mem.sv | 70 +++++++
 tb/tb_instr_mem.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/instr_mem.sv
// instr_mem: 16 x 16 instruction memory for the fetch stage.
//
// The read path is combinational, so decode sees the word at addr in the same cycle.
// A synchronous load port lets a bench or boot loader overwrite the program.
// A synchronous reset reloads the default image: word k = 16'hA000 | k.
//
// Ports:
//   clk          clock; all state changes happen on the rising edge
//   rst          synchronous, active-high reset; loads the default image
//   addr         read word address (fetch PC index, word-granular)
//   instruction  word stored at addr; 16'h0000 when addr >= DEPTH
//   wr_en        load-port write strobe
//   wr_addr      load-port word address; the write is ignored when it is >= DEPTH
//   wr_data      load-port data
//   mem          flattened image, word k at [k*DATA_W +: DATA_W]
//                (this port exists only when IMEM_DUMP_EN is defined)
//
// Build option: define IMEM_DUMP_EN to expose the mem port.

module instr_mem #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] instruction,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
`ifdef IMEM_DUMP_EN
    ,
    output logic [DEPTH*DATA_W-1:0] mem
`endif
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Reset takes priority over a write on the same edge. There is no bypass,
    // so a read of the word being written shows the new value only after the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                mem_q[k] <= DATA_W'(32'hA000 | 32'(k));
            end
        end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Out-of-range fetches return a NOP. This case cannot occur with the
    // default parameters.
    always_comb begin
        instruction = '0;
        if (32'(addr) < DEPTH) begin
            instruction = mem_q[addr];
        end
    end

`ifdef IMEM_DUMP_EN
    always_comb begin
        mem = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            mem[k*DATA_W +: DATA_W] = mem_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem.sv
module tb_instr_mem;

    logic        clk;
    logic        rst;
    logic [3:0]  addr;
    logic [15:0] instruction;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
`ifdef IMEM_DUMP_EN
    logic [255:0] mem;
`endif

    instr_mem #(
        .DATA_W(16),
        .ADDR_W(4),
        .DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .instruction(instruction),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
`ifdef IMEM_DUMP_EN
        ,
        .mem        (mem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model [16];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard read: expected value is queued as the address is driven and
    // popped once the combinational output has settled.
    task automatic read_chk(input logic [3:0] a, input logic [15:0] e, input string name);
        logic [15:0] exp;
        addr = a;
        exp_q.push_back(e);
        #1;
        exp = exp_q.pop_front();
        check(name, instruction, exp);
    endtask

    // Advance one rising edge and move 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) model[k] = 16'hA000 | 16'(k);
    endtask

    initial begin
        vec_t vecs[20];

        rst     = 1'b0;
        addr    = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        @(negedge clk);

        do_reset();

        // The test-plan probes come first, followed by a full sweep with no clock edges.
        vecs[0] = '{4'd0,  16'hA000};
        vecs[1] = '{4'd4,  16'hA004};
        vecs[2] = '{4'd8,  16'hA008};
        vecs[3] = '{4'd10, 16'hA00A};
        for (int i = 0; i < 16; i++) vecs[4+i] = '{4'(i), 16'hA000 + 16'(i)};
        for (int i = 0; i < 20; i++) read_chk(vecs[i].a, vecs[i].exp, "reset_image");

`ifdef IMEM_DUMP_EN
        check("dump_w0",  mem[15:0],    16'hA000);
        check("dump_w15", mem[255:240], 16'hA00F);
`endif

        // A write is invisible before its edge and visible after it.
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h1234;
        read_chk(4'd4, 16'hA004, "rdw_before");
        tick();
        wr_en = 1'b0;
        read_chk(4'd4, 16'h1234, "rdw_after");
        read_chk(4'd5, 16'hA005, "neighbour_untouched");

        // Reset and write on the same edge: reset wins.
        rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hFFFF;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        read_chk(4'd3, 16'hA003, "rst_over_wr");
        read_chk(4'd4, 16'hA004, "rst_reverts_w4");

        // Written word reverts on a later reset.
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        read_chk(4'd15, 16'hBEEF, "w15_written");
        do_reset();
        read_chk(4'd15, 16'hA00F, "w15_reset");

`ifdef IMEM_DUMP_EN
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0F0F;
        tick();
        wr_en = 1'b0;
        check("dump_w2", mem[47:32], 16'h0F0F);
        model[2] = 16'h0F0F;
`endif

        // Random writes against a reference model; some cycles have wr_en low.
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  wa;
            logic [15:0] wd;
            logic        we;
            wa = 4'($urandom_range(0, 15));
            wd = 16'($urandom);
            we = 1'($urandom_range(0, 3) != 0);
            wr_en = we; wr_addr = wa; wr_data = wd;
            tick();
            if (we) model[wa] = wd;
        end
        wr_en = 1'b0;
        for (int k = 0; k < 16; k++) read_chk(4'(k), model[k], "random_model");
`ifdef IMEM_DUMP_EN
        for (int k = 0; k < 16; k++) check("dump_model", mem[k*16 +: 16], model[k]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
